// File: rtl/fp_accumulator.sv
// Streaming IEEE-754 double accumulator with valid/ready framing and sticky NaN.
// Optional status flags output (out_flags) is enabled by defining FP_ACC_FLAGS_EN.

module FPAdder (
    input  logic [63:0] A,
    input  logic [63:0] B,
    output logic [63:0] out
);
    localparam logic [63:0] CNAN = 64'h7ff8000000000000;

    logic         w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic         w_swap, w_eff_sub, w_sign, w_rnd_up;
    logic [63:0]  w_l, w_s;
    logic [11:0]  w_e_l, w_e_s, w_dist, w_dist_c, w_sh, w_e_n, w_e_f;
    logic [52:0]  w_sig_l, w_sig_s;
    logic [111:0] w_shift_ext;
    logic [55:0]  w_aligned, w_big, w_norm;
    logic [56:0]  w_raw;
    logic [6:0]   w_lz;
    logic [53:0]  w_mr;
    logic [51:0]  w_frac;

    assign w_a_nan = (A[62:52] == 11'h7ff) && (A[51:0] != 52'd0);
    assign w_b_nan = (B[62:52] == 11'h7ff) && (B[51:0] != 52'd0);
    assign w_a_inf = (A[62:52] == 11'h7ff) && (A[51:0] == 52'd0);
    assign w_b_inf = (B[62:52] == 11'h7ff) && (B[51:0] == 52'd0);

    // NOTE: every variable gets a value on every path through this block, so no latches are inferred.
    always_comb begin
        // Order operands by magnitude so the subtraction below never goes negative.
        w_swap      = (B[62:0] > A[62:0]);
        w_l         = w_swap ? B : A;
        w_s         = w_swap ? A : B;
        w_e_l       = (w_l[62:52] == 11'd0) ? 12'd1 : {1'b0, w_l[62:52]};
        w_e_s       = (w_s[62:52] == 11'd0) ? 12'd1 : {1'b0, w_s[62:52]};
        w_sig_l     = {(w_l[62:52] != 11'd0), w_l[51:0]};
        w_sig_s     = {(w_s[62:52] != 11'd0), w_s[51:0]};
        w_dist      = w_e_l - w_e_s;
        w_dist_c    = (w_dist > 12'd57) ? 12'd57 : w_dist;
        w_shift_ext = {w_sig_s, 59'd0} >> w_dist_c;
        w_aligned   = {w_shift_ext[111:57], |w_shift_ext[56:0]};
        w_big       = {w_sig_l, 3'b000};
        w_eff_sub   = w_l[63] ^ w_s[63];
        if (w_eff_sub)
            w_raw = {1'b0, w_big} - {1'b0, w_aligned};
        else
            w_raw = {1'b0, w_big} + {1'b0, w_aligned};
        w_sign = (w_eff_sub && (w_raw == 57'd0)) ? 1'b0 : w_l[63];

        w_lz = 7'd56;
        for (int i = 0; i < 56; i++)
            if (w_raw[i]) w_lz = 7'(55 - i);

        // Left shift is capped so the exponent bottoms out at the subnormal range.
        if (w_raw[56]) begin
            w_norm = {w_raw[56:2], |w_raw[1:0]};
            w_sh   = 12'd0;
            w_e_n  = w_e_l + 12'd1;
        end else begin
            w_sh   = ({5'd0, w_lz} > (w_e_l - 12'd1)) ? (w_e_l - 12'd1) : {5'd0, w_lz};
            w_norm = w_raw[55:0] << w_sh;
            w_e_n  = w_e_l - w_sh;
        end

        w_rnd_up = w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0]);
        w_mr     = {1'b0, w_norm[55:3]} + {53'd0, w_rnd_up};
        w_e_f    = w_mr[53] ? (w_e_n + 12'd1) : (w_mr[52] ? w_e_n : 12'd0);
        w_frac   = w_mr[53] ? w_mr[52:1] : w_mr[51:0];

        if (w_a_nan || w_b_nan)
            out = CNAN;
        else if (w_a_inf && w_b_inf && (A[63] != B[63]))
            out = CNAN;
        else if (w_a_inf)
            out = A;
        else if (w_b_inf)
            out = B;
        else if (w_e_f >= 12'd2047)
            out = {w_sign, 11'h7ff, 52'd0};
        else
            out = {w_sign, w_e_f[10:0], w_frac};
    end
endmodule

module fp_accumulator #(
    parameter int ADD_REG = 0,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [63:0]        in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [63:0]        out_data,
    output logic [COUNT_W-1:0] out_count
`ifdef FP_ACC_FLAGS_EN
    ,
    output logic [2:0]         out_flags
`endif
);
    localparam logic [63:0] CNAN    = 64'h7ff8000000000000;
    localparam bit          USE_REG = (ADD_REG != 0);

    typedef enum logic [1:0] {ST_ACC, ST_WAIT, ST_DONE} state_t;

    state_t             r_state, w_next;
    logic [63:0]        r_acc, r_pipe;
    logic               r_last_q;
    logic [COUNT_W-1:0] r_count;
    logic [63:0]        w_sum, w_sum_fix;
    logic               w_beat, w_hs, w_in_nan, w_sum_nan, w_acc_nan;

    FPAdder u_add (.A(r_acc), .B(in_data), .out(w_sum));

    assign w_in_nan  = (in_data[62:52] == 11'h7ff) && (in_data[51:0] != 52'd0);
    assign w_sum_nan = (w_sum[62:52] == 11'h7ff) && (w_sum[51:0] != 52'd0);
    assign w_acc_nan = (r_acc[62:52] == 11'h7ff) && (r_acc[51:0] != 52'd0);
    assign w_sum_fix = (w_in_nan || w_sum_nan || w_acc_nan) ? CNAN : w_sum;
    assign w_beat    = in_valid && (r_state == ST_ACC);
    assign w_hs      = (r_state == ST_DONE) && out_ready;

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_ACC: begin
                in_ready = 1'b1;
                if (w_beat)
                    w_next = USE_REG ? ST_WAIT : (in_last ? ST_DONE : ST_ACC);
            end
            ST_WAIT: w_next = r_last_q ? ST_DONE : ST_ACC;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = ST_ACC;
            end
            default: w_next = ST_ACC;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_ACC;
            r_acc    <= 64'd0;
            r_pipe   <= 64'd0;
            r_last_q <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_ACC: begin
                    if (w_beat) begin
                        if (r_count != {COUNT_W{1'b1}})
                            r_count <= r_count + 1'b1;
                        if (USE_REG) begin
                            r_pipe   <= w_sum_fix;
                            r_last_q <= in_last;
                        end else begin
                            r_acc <= w_sum_fix;
                        end
                    end
                end
                ST_WAIT: r_acc <= r_pipe;
                ST_DONE: begin
                    if (w_hs) begin
                        r_acc   <= 64'd0;
                        r_count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data  = (r_state == ST_DONE) ? r_acc : 64'd0;
    assign out_count = (r_state == ST_DONE) ? r_count : '0;

`ifdef FP_ACC_FLAGS_EN
    logic r_invalid, r_overflow;
    logic w_acc_inf, w_in_inf, w_sum_inf, w_inf_clash, w_ovf;

    assign w_acc_inf   = (r_acc[62:52] == 11'h7ff) && (r_acc[51:0] == 52'd0);
    assign w_in_inf    = (in_data[62:52] == 11'h7ff) && (in_data[51:0] == 52'd0);
    assign w_sum_inf   = (w_sum[62:52] == 11'h7ff) && (w_sum[51:0] == 52'd0);
    assign w_inf_clash = w_acc_inf && w_in_inf && (r_acc[63] != in_data[63]);
    assign w_ovf       = w_sum_inf && (r_acc[62:52] != 11'h7ff) && (in_data[62:52] != 11'h7ff);

    always_ff @(posedge clk) begin
        if (rst || w_hs) begin
            r_invalid  <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_beat) begin
            r_invalid  <= r_invalid | w_in_nan | w_inf_clash;
            r_overflow <= r_overflow | w_ovf;
        end
    end

    assign out_flags = (r_state == ST_DONE) ?
                       {r_invalid, r_overflow, (r_acc[62:0] == 63'd0)} : 3'b000;
`endif
endmodule
